// File: rtl/c17_pkg.sv
// c17_pkg: shared types and constants for the c17 self-test controller.
//   state_e    - controller FSM states
//   SIG_W      - MISR/signature width
//   PAT_W      - pattern counter width (drives N1,N2,N3,N6,N7)
//   KEY_W      - key width (keyinput24..26)
//   MISR_POLY  - MISR feedback polynomial
//   misr_step  - one MISR update with 2-bit compaction input
package c17_pkg;

  localparam int unsigned SIG_W = 16;
  localparam int unsigned PAT_W = 5;
  localparam int unsigned KEY_W = 3;

  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StCapture,
    StDone
  } state_e;

  // Shift left, fold the MSB back through the polynomial, then mix in {N23,N22}.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                 input logic [1:0]       din);
    logic [SIG_W-1:0] nxt;
    nxt = {cur[SIG_W-2:0], 1'b0};
    if (cur[SIG_W-1]) begin
      nxt = nxt ^ MISR_POLY;
    end
    nxt = nxt ^ {{(SIG_W-2){1'b0}}, din};
    return nxt;
  endfunction

endpackage

// File: rtl/c17_misr.sv
// c17_misr: 16-bit multiple-input signature register.
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset, loads SEED
//   clear    - synchronous reload to SEED (takes priority over enable)
//   enable   - advance the MISR by one step using din
//   din      - {N23, N22} from the c17 core
//   sig      - current MISR contents
//   sig_next - value the MISR would take on an enabled step
module c17_misr
  import c17_pkg::*;
#(
  parameter logic [SIG_W-1:0] SEED = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [1:0]       din,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_next
);

  logic [SIG_W-1:0] sig_q;

  always_comb begin
    sig_next = misr_step(sig_q, din);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= SEED;
    end else if (clear) begin
      sig_q <= SEED;
    end else if (enable) begin
      sig_q <= sig_next;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl: self-test controller for the key-locked c17 benchmark.
// Latches a key and golden signature on start, walks the c17 inputs through
// patterns 0..NUM_PATTERNS-1 (APPLY then CAPTURE per pattern), compacts the
// c17 outputs into a MISR and reports pass/fail when done.
//   clk, rst                    - clock / asynchronous active-high reset
//   start                       - run request, honoured only in IDLE or DONE
//   key_in, golden_sig          - key under test and expected signature
//   N22, N23                    - c17 outputs
//   N1, N2, N3, N6, N7          - c17 inputs (registered pattern, N1 = MSB)
//   keyinput24..26              - latched key (registered)
//   busy, done, pass, signature - status and current MISR value
module c17_bist_ctrl
  import c17_pkg::*;
#(
  parameter int unsigned       NUM_PATTERNS = 32,
  parameter logic [SIG_W-1:0]  SEED         = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic             N22,
  input  logic             N23,
  output logic             N1,
  output logic             N2,
  output logic             N3,
  output logic             N6,
  output logic             N7,
  output logic             keyinput24,
  output logic             keyinput25,
  output logic             keyinput26,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam logic [PAT_W-1:0] LastPat = PAT_W'(NUM_PATTERNS - 1);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   p_q, p_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [SIG_W-1:0]   golden_q, golden_d;
  logic               pass_q, pass_d;
  logic               misr_clear, misr_en;
  logic [SIG_W-1:0]   sig, sig_next;

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    key_d      = key_q;
    golden_d   = golden_q;
    pass_d     = pass_q;
    misr_clear = 1'b0;
    misr_en    = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          key_d      = key_in;
          golden_d   = golden_sig;
          p_d        = '0;
          pass_d     = 1'b0;
          misr_clear = 1'b1;
          state_d    = StApply;
        end
      end
      // One settle cycle for the c17 output before it is compacted.
      StApply: state_d = StCapture;
      StCapture: begin
        misr_en = 1'b1;
        if (p_q == LastPat) begin
          // Compare against the value being written this edge, not the stale one.
          pass_d  = (sig_next == golden_q);
          state_d = StDone;
        end else begin
          p_d     = p_q + 5'd1;
          state_d = StApply;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      p_q      <= '0;
      key_q    <= '0;
      golden_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      key_q    <= key_d;
      golden_q <= golden_d;
      pass_q   <= pass_d;
    end
  end

  c17_misr #(
    .SEED (SEED)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .clear    (misr_clear),
    .enable   (misr_en),
    .din      ({N23, N22}),
    .sig      (sig),
    .sig_next (sig_next)
  );

  // The pattern counter register doubles as the registered c17 input drive.
  assign {N1, N2, N3, N6, N7}                = p_q;
  assign {keyinput26, keyinput25, keyinput24} = key_q;
  assign busy      = (state_q == StApply) || (state_q == StCapture);
  assign done      = (state_q == StDone);
  assign pass      = pass_q & done;
  assign signature = sig;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
module tb_c17_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start1;
  logic [2:0]  key_in, key1;
  logic [15:0] golden_sig, golden1;

  logic N1, N2, N3, N6, N7, N22, N23;
  logic keyinput24, keyinput25, keyinput26;
  logic busy, done, pass;
  logic [15:0] signature;

  logic s_N1, s_N2, s_N3, s_N6, s_N7;
  logic s_k24, s_k25, s_k26;
  logic s_busy, s_done, s_pass;
  logic [15:0] s_sig;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pass;
    logic [15:0] sig;
    int          cycles;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Key-locked c17 reference: XNOR key gates on N11, N16, N19 (correct key 3'b111).
  function automatic logic [1:0] c17_ref(input logic [4:0] pat, input logic [2:0] key);
    logic n1, n2, n3, n6, n7, n10, n11, n11k, n16, n16k, n19, n19k, n22, n23;
    {n1, n2, n3, n6, n7} = pat;
    n10  = ~(n1 & n3);
    n11  = ~(n3 & n6);
    n11k = ~(n11 ^ key[0]);
    n16  = ~(n2 & n11k);
    n16k = ~(n16 ^ key[1]);
    n19  = ~(n11k & n7);
    n19k = ~(n19 ^ key[2]);
    n22  = ~(n10 & n16k);
    n23  = ~(n16k & n19k);
    return {n23, n22};
  endfunction

  function automatic logic [15:0] ref_sig(input int n, input logic [2:0] key);
    logic [15:0] s;
    logic [1:0]  d;
    logic        fb;
    s = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      d  = c17_ref(5'(i), key);
      fb = s[15];
      s  = {s[14:0], 1'b0};
      if (fb) s = s ^ 16'h1021;
      s = s ^ {14'b0, d};
    end
    return s;
  endfunction

  assign {N23, N22} = c17_ref({N1, N2, N3, N6, N7}, {keyinput26, keyinput25, keyinput24});

  c17_bist_ctrl #(.NUM_PATTERNS(32), .SEED(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .golden_sig(golden_sig),
    .N22(N22), .N23(N23), .N1(N1), .N2(N2), .N3(N3), .N6(N6), .N7(N7),
    .keyinput24(keyinput24), .keyinput25(keyinput25), .keyinput26(keyinput26),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  c17_bist_ctrl #(.NUM_PATTERNS(1), .SEED(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key_in(key1), .golden_sig(golden1),
    .N22(1'b1), .N23(1'b0), .N1(s_N1), .N2(s_N2), .N3(s_N3), .N6(s_N6), .N7(s_N7),
    .keyinput24(s_k24), .keyinput25(s_k25), .keyinput26(s_k26),
    .busy(s_busy), .done(s_done), .pass(s_pass), .signature(s_sig)
  );

  // Full 32-pattern run; optionally pulses start with other key/golden in cycle 10.
  task automatic run_full(input string name, input logic [2:0] key, input logic [15:0] gold,
                          input bit inject);
    exp_t        e;
    int          cnt;
    logic [15:0] s_exp;
    s_exp    = ref_sig(32, key);
    e.pass   = (s_exp == gold);
    e.sig    = s_exp;
    e.cycles = 64;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; key_in = key; golden_sig = gold;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy, done, pass, signature} !== {3'b100, 16'hFFFF}) begin
      errors++;
      $display("FAIL %s cycle1 busy/done/pass/sig got %b%b%b %h want 100 ffff",
               name, busy, done, pass, signature);
    end
    cnt = 0;
    while (done !== 1'b1 && cnt < 200) begin
      checks++;
      if ({N1, N2, N3, N6, N7} !== 5'(cnt / 2) || busy !== 1'b1 ||
          {keyinput26, keyinput25, keyinput24} !== key) begin
        errors++;
        $display("FAIL %s cycle%0d pat/busy/key got %b %b %b want %b 1 %b", name, cnt + 1,
                 {N1, N2, N3, N6, N7}, busy, {keyinput26, keyinput25, keyinput24},
                 5'(cnt / 2), key);
      end
      if (inject && cnt == 9) begin
        start = 1'b1; key_in = ~key; golden_sig = ~gold;
      end
      @(posedge clk); #1;
      cnt++;
      start = 1'b0; key_in = key; golden_sig = gold;
    end
    e = sb.pop_front();
    checks++;
    if (cnt !== e.cycles) begin
      errors++;
      $display("FAIL %s done_latency got %0d want %0d", name, cnt, e.cycles);
    end
    checks++;
    if ({done, busy, pass} !== {2'b10, e.pass} || signature !== e.sig) begin
      errors++;
      $display("FAIL %s result done/busy/pass/sig got %b%b%b %h want 10%b %h",
               name, done, busy, pass, signature, e.pass, e.sig);
    end
    checks++;
    if ({N1, N2, N3, N6, N7} !== 5'b11111 || {keyinput26, keyinput25, keyinput24} !== key) begin
      errors++;
      $display("FAIL %s held pat/key got %b %b want 11111 %b", name,
               {N1, N2, N3, N6, N7}, {keyinput26, keyinput25, keyinput24}, key);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    key_in = 3'b000; key1 = 3'b000; golden_sig = '0; golden1 = '0;
    #1;
    checks++;
    if ({N1, N2, N3, N6, N7, keyinput26, keyinput25, keyinput24, busy, done, pass, signature}
        !== {11'b0, 16'hFFFF}) begin
      errors++;
      $display("FAIL reset outputs got %b %h want 00000000000 ffff",
               {N1, N2, N3, N6, N7, keyinput26, keyinput25, keyinput24, busy, done, pass},
               signature);
    end
    checks++;
    if ({s_busy, s_done, s_pass, s_sig} !== {3'b000, 16'hFFFF}) begin
      errors++;
      $display("FAIL reset1 busy/done/pass/sig got %b%b%b %h want 000 ffff",
               s_busy, s_done, s_pass, s_sig);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single(input logic [15:0] gold);
    exp_t e;
    int   cnt;
    e.pass = (gold == 16'hEFDE); e.sig = 16'hEFDE; e.cycles = 2;
    sb.push_back(e);
    @(negedge clk);
    start1 = 1'b1; golden1 = gold; key1 = 3'b101;
    @(posedge clk); #1;
    start1 = 1'b0;
    cnt = 0;
    while (s_done !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    e = sb.pop_front();
    checks++;
    if (cnt !== e.cycles || s_sig !== e.sig || s_pass !== e.pass) begin
      errors++;
      $display("FAIL single_step gold=%h got lat %0d sig %h pass %b want %0d %h %b",
               gold, cnt, s_sig, s_pass, e.cycles, e.sig, e.pass);
    end
  endtask

  task automatic test_restart(input logic [15:0] gold);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL restart_precondition done got %b want 1", done);
    end
    run_full("restart", 3'b111, gold, 1'b0);
  endtask

  task automatic test_midrun_reset(input logic [15:0] gold);
    @(negedge clk);
    start = 1'b1; key_in = 3'b111; golden_sig = gold;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({N1, N2, N3, N6, N7, keyinput26, keyinput25, keyinput24, busy, done, pass, signature}
        !== {11'b0, 16'hFFFF}) begin
      errors++;
      $display("FAIL midrun_reset outputs got %b %h want 00000000000 ffff",
               {N1, N2, N3, N6, N7, keyinput26, keyinput25, keyinput24, busy, done, pass},
               signature);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset busy/done got %b%b want 00", busy, done);
    end
    run_full("after_reset", 3'b111, gold, 1'b0);
  endtask

  initial begin
    logic [15:0] gold_ok;
    gold_ok = ref_sig(32, 3'b111);
    test_reset();
    run_full("sequence_good_key", 3'b111, gold_ok, 1'b0);
    run_full("wrong_key", 3'b010, gold_ok, 1'b0);
    run_full("start_while_busy", 3'b111, gold_ok, 1'b1);
    test_restart(gold_ok);
    test_midrun_reset(gold_ok);
    test_single(16'hEFDE);
    test_single(16'hEFDF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c17_bist_ctrl.md
# c17_bist_ctrl

Self-test controller for the key-locked c17 benchmark. It latches a 3-bit key, drives that key onto the c17 key inputs, and walks the c17 primary inputs through an exhaustive counting sequence. It compacts the c17 outputs into a 16-bit MISR and compares the final signature against a golden value. It wraps the combinational c17 core, feeding N1/N2/N3/N6/N7 and keyinput24..26, and consuming N22/N23, so a key's correctness is measured in hardware.

## Interface
- NUM_PATTERNS, 32, number of input patterns applied, legal 1..32; patterns are indices 0..NUM_PATTERNS-1
- SEED, 16'hFFFF, MISR value at reset and at run start
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  run request; accepted only in IDLE or DONE
- key_in  in  3  key to test; bit2→keyinput26, bit1→keyinput25, bit0→keyinput24; sampled when start is accepted
- golden_sig  in  16  expected signature; sampled when start is accepted
- N22, N23  in  1 each  c17 outputs
- N1, N2, N3, N6, N7  out  1 each  c17 inputs, registered
- keyinput24, keyinput25, keyinput26  out  1 each  latched key, registered
- busy  out  1  high in APPLY/CAPTURE
- done  out  1  high in DONE; held until the next accepted start or reset
- pass  out  1  valid only while done; 1 iff signature == latched golden
- signature  out  16  current MISR contents

## Operation
- States: IDLE, APPLY, CAPTURE, DONE.
- IDLE/DONE with start=1: latch key_in and golden_sig; MISR←SEED; p←0; done←0; pass←0; go to APPLY. A start in DONE restarts.
- APPLY: {N1,N2,N3,N6,N7} = p[4:0], with N1 as MSB. Next state is CAPTURE. This cycle lets the c17 output settle.
- CAPTURE: MISR←{MISR[14:0],1'b0} ^ (MISR[15] ? 16'h1021 : 0) ^ {14'b0,N23,N22}.
  - If p == NUM_PATTERNS-1: go to DONE; pass←(next MISR == golden).
  - Otherwise: p←p+1; go to APPLY.
- start in APPLY/CAPTURE is ignored. No queuing.
- p is 5 bits. Terminal compare prevents wrap, so NUM_PATTERNS=32 ends at p=31.
- Pattern outputs keep the last applied value in DONE. They reset to 0.
- Reset values: all pattern and key outputs 0; busy 0; done 0; pass 0; signature=SEED; state IDLE.
- Reset mid-run aborts immediately. Nothing is retained, and the next run needs a fresh start.

## Timing
- Start accepted at edge 0. APPLY for p=0 occupies cycle 1. Each pattern takes 2 cycles: APPLY then CAPTURE.
- First MISR update is at edge 2. Last update is at edge 2·NUM_PATTERNS.
- done and pass are visible from cycle 2·NUM_PATTERNS+1. For the default this is cycle 65, 65 cycles after start.
- busy rises in cycle 1 and falls at the same edge done rises.
- Key outputs change only at start acceptance and reset. They are stable throughout a run.
- N22/N23 are sampled only on CAPTURE edges. Glitches during APPLY are irrelevant.

## Structure
- Shared package c17_pkg: state enum; MISR polynomial 16'h1021; SIG_W=16; PAT_W=5; KEY_W=3.
- Optional sub-module c17_misr holding the 16-bit register and its update. Signals: clear-to-seed, enable, 2-bit data in.
- The controller FSM, pattern counter and key/golden latches live in c17_bist_ctrl.

## Test plan
- Sequence: NUM_PATTERNS=32, any key → N1..N7 count 00000, 00001 … 11111, each held 2 cycles. busy is high for 64 cycles, then done=1.
- Single-step MISR: NUM_PATTERNS=1, bench ties N22=1, N23=0 → signature = 16'hEFDE at done. pass=1 with golden=16'hEFDE, pass=0 with golden=16'hEFDF.
- Full run against c17 with the correct key 3'b111 and golden from a bench reference model → pass=1 at cycle 65. Wrong key 3'b010 → pass=0, and keyinput26..24=0,1,0 throughout the run.
- Start while busy: pulse start at cycle 10 with a different key_in → ignored. Key outputs, count and completion cycle are unchanged.
- Reset at cycle 30 → all outputs go to reset values asynchronously (signature=16'hFFFF). A new start then completes normally 65 cycles later.
- Restart from DONE: start with done=1 → done drops next cycle. Signature reseeds to 16'hFFFF and the pattern restarts at 00000.
